// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler and the ALU it fronts.
package alu_sched_pkg;

   localparam int ALU_OPW     = 5;
   localparam int ALU_WIDTH   = 32;
   localparam int ALU_LAT_MIN = 1;
   localparam int ALU_LAT_MAX = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;

   function automatic logic lat_ok(input int lat);
      return (lat >= ALU_LAT_MIN) && (lat <= ALU_LAT_MAX);
   endfunction

endpackage

// File: rtl/alu_sched_arb.sv
// Two-way request grant: round-robin on last_grant by default, fixed priority
// to port 0 when ALU_SCHED_PRIO_EN is defined.
module alu_sched_arb (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

`ifdef ALU_SCHED_PRIO_EN
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   always_comb begin
      grant = 2'b00;
      if (valid[0])      grant = 2'b01;
      else if (valid[1]) grant = 2'b10;
   end
`else
   // On a tie the port that did not win last time gets the grant.
   always_comb begin
      grant = 2'b00;
      case (valid)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_grant ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end
`endif

endmodule

// File: rtl/alu_sched.sv
// Shares one ALU between two requesters; one operation in flight at a time.
// Arbitration mode selected by ALU_SCHED_PRIO_EN (see alu_sched_arb).
module alu_sched
   import alu_sched_pkg::*;
#(
   parameter int WIDTH   = ALU_WIDTH,
   parameter int OPW     = ALU_OPW,
   parameter int ALU_LAT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [OPW-1:0]   req0_opcode,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [OPW-1:0]   req1_opcode,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic [OPW-1:0]   alu_opcode,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_enable,
   input  logic [WIDTH-1:0] alu_out,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   if (!lat_ok(ALU_LAT)) begin : g_bad_lat
      $error("alu_sched: ALU_LAT out of range 1..15");
   end

   localparam logic [3:0] LAT_LD = 4'(ALU_LAT);

   state_t     state;
   logic [3:0] cnt;
   logic       owner;
   logic       last_grant;
   logic [1:0] grant;
   logic       accept;

   alu_sched_arb u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // Valid/ready: a transfer happens on a rising edge where both are high;
   // the source holds valid and payload stable until then. Ready is forced
   // low while reset is asserted.
   assign accept     = (state == ST_IDLE) && (|grant);
   assign req0_ready = rst_n && (state == ST_IDLE) && grant[0];
   assign req1_ready = rst_n && (state == ST_IDLE) && grant[1];
   assign dbg_state  = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_enable <= 1'b0;
         rsp_data   <= '0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  alu_opcode <= grant[1] ? req1_opcode : req0_opcode;
                  alu_a      <= grant[1] ? req1_a      : req0_a;
                  alu_b      <= grant[1] ? req1_b      : req0_b;
                  owner      <= grant[1];
                  last_grant <= grant[1];
                  alu_enable <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               alu_enable <= 1'b0;
               cnt        <= LAT_LD;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               // Counter value 1 means this edge is ALU_LAT edges after enable.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  rsp_data   <= alu_out;
                  rsp0_valid <= ~owner;
                  rsp1_valid <= owner;
                  state      <= ST_RESP;
               end
            end
            ST_RESP: begin
               if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: four instances at ALU_LAT 1, 3, 4, 15 with XOR ALU stubs.
module tb_alu_sched;

   localparam int NI = 4;

   function automatic int lat_of(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         2:       return 4;
         default: return 15;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_n       [NI];
   logic        req0_valid  [NI];
   logic        req0_ready  [NI];
   logic [4:0]  req0_opcode [NI];
   logic [31:0] req0_a      [NI];
   logic [31:0] req0_b      [NI];
   logic        req1_valid  [NI];
   logic        req1_ready  [NI];
   logic [4:0]  req1_opcode [NI];
   logic [31:0] req1_a      [NI];
   logic [31:0] req1_b      [NI];
   logic        rsp0_valid  [NI];
   logic        rsp0_ready  [NI];
   logic        rsp1_valid  [NI];
   logic        rsp1_ready  [NI];
   logic [31:0] rsp_data    [NI];
   logic [4:0]  alu_opcode  [NI];
   logic [31:0] alu_a       [NI];
   logic [31:0] alu_b       [NI];
   logic        alu_enable  [NI];
   logic        busy        [NI];
   logic [1:0]  dbg_state   [NI];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = lat_of(g);
      logic [31:0] stub_out  = 32'hDEADBEEF;
      logic [31:0] stub_pend = 32'h0;
      int          stub_cnt  = 0;
      logic        stub_live = 1'b0;

      // ALU stub: result a^b appears only on the edge ALU_LAT edges after
      // the enable edge, and is replaced by junk one edge later.
      always @(posedge clk) begin
         if (stub_live) begin
            stub_out  <= 32'hDEADBEEF;
            stub_live <= 1'b0;
         end
         if (alu_enable[g]) begin
            if (L == 1) begin
               stub_out  <= alu_a[g] ^ alu_b[g];
               stub_live <= 1'b1;
            end else begin
               stub_cnt  <= L - 1;
               stub_pend <= alu_a[g] ^ alu_b[g];
            end
         end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
               stub_out  <= stub_pend;
               stub_live <= 1'b1;
            end
         end
      end

      alu_sched #(.WIDTH(32), .OPW(5), .ALU_LAT(L)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n[g]),
         .req0_valid  (req0_valid[g]),
         .req0_ready  (req0_ready[g]),
         .req0_opcode (req0_opcode[g]),
         .req0_a      (req0_a[g]),
         .req0_b      (req0_b[g]),
         .req1_valid  (req1_valid[g]),
         .req1_ready  (req1_ready[g]),
         .req1_opcode (req1_opcode[g]),
         .req1_a      (req1_a[g]),
         .req1_b      (req1_b[g]),
         .rsp0_valid  (rsp0_valid[g]),
         .rsp0_ready  (rsp0_ready[g]),
         .rsp1_valid  (rsp1_valid[g]),
         .rsp1_ready  (rsp1_ready[g]),
         .rsp_data    (rsp_data[g]),
         .alu_opcode  (alu_opcode[g]),
         .alu_a       (alu_a[g]),
         .alu_b       (alu_b[g]),
         .alu_enable  (alu_enable[g]),
         .alu_out     (stub_out),
         .busy        (busy[g]),
         .dbg_state   (dbg_state[g])
      );
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   task automatic set_req(input int k, input bit p, input logic v,
                          input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (p) begin
         req1_valid[k] = v; req1_opcode[k] = op; req1_a[k] = a; req1_b[k] = b;
      end else begin
         req0_valid[k] = v; req0_opcode[k] = op; req0_a[k] = a; req0_b[k] = b;
      end
   endtask

   function automatic logic rdy(input int k, input bit p);
      return p ? req1_ready[k] : req0_ready[k];
   endfunction

   function automatic logic rv(input int k, input bit p);
      return p ? rsp1_valid[k] : rsp0_valid[k];
   endfunction

   // Full single operation with response ready held high.
   task automatic do_op(input int k, input bit p, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv);
      bit got;
      int n;
      bit bad_en;
      bit bad_hold;
      got = 0; n = 0; bad_en = 0; bad_hold = 0;
      @(negedge clk);
      set_req(k, p, 1'b1, op, a, b);
      for (int i = 0; i < 40; i++) begin
         #1;
         if (rdy(k, p)) begin got = 1; break; end
         @(negedge clk);
      end
      check("accept", {31'b0, got}, 32'd1);
      if (!got) begin
         set_req(k, p, 1'b0, 5'h0, 32'h0, 32'h0);
         return;
      end
      check("other_ready", {31'b0, rdy(k, !p)}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      n = 1;
      set_req(k, p, 1'b0, ~op, ~a, a ^ b);
      #1;
      check("enable_exec", {31'b0, alu_enable[k]}, 32'd1);
      check("alu_opcode", {27'b0, alu_opcode[k]}, {27'b0, op});
      check("alu_a_latched", alu_a[k], a);
      check("alu_b_latched", alu_b[k], b);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         #1;
         if (rv(k, p)) break;
         if (alu_enable[k]) bad_en = 1;
         if (alu_a[k] !== a || alu_b[k] !== b || alu_opcode[k] !== op) bad_hold = 1;
      end
      check("enable_one_cycle", {31'b0, bad_en}, 32'd0);
      check("operand_hold", {31'b0, bad_hold}, 32'd0);
      check("latency", n, lat_of(k) + 2);
      check("rsp_valid", {31'b0, rv(k, p)}, 32'd1);
      check("rsp_data", rsp_data[k], expv);
      check("other_rsp_valid", {31'b0, rv(k, !p)}, 32'd0);
      @(negedge clk);
      #1;
      check("idle_after_rsp", {30'b0, busy[k], rv(k, p)}, 32'd0);
   endtask

   typedef struct {
      int          k;
      bit          p;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;

   vec_t vt[7];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gr[4];
      int gt[4];
      int ng;
      int nn;
      bit both;
      bit got;
      bit bad;
      logic [31:0] d;

      vt[0] = '{0, 1'b0, 5'b01001, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0};
      vt[1] = '{0, 1'b1, 5'h03,    32'h12345678, 32'h0000FFFF, 32'h1234A987};
      vt[2] = '{1, 1'b0, 5'h1F,    32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFFF};
      vt[3] = '{1, 1'b1, 5'h00,    32'h80000001, 32'h00000001, 32'h80000000};
      vt[4] = '{3, 1'b0, 5'h10,    32'hCAFEF00D, 32'h0000000F, 32'hCAFEF002};
      vt[5] = '{3, 1'b1, 5'h01,    32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
      vt[6] = '{2, 1'b0, 5'h07,    32'h11111111, 32'h22222222, 32'h33333333};

      // Clock/reset
      for (int k = 0; k < NI; k++) begin
         rst_n[k] = 1'b0;
         set_req(k, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
         set_req(k, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
         rsp0_ready[k] = 1'b1;
         rsp1_ready[k] = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("reset_flags", {26'b0, req0_ready[k], req1_ready[k], rsp0_valid[k],
                               rsp1_valid[k], alu_enable[k], busy[k]}, 32'd0);
         check("reset_data", rsp_data[k] | alu_a[k] | alu_b[k], 32'd0);
         check("reset_state", {25'b0, alu_opcode[k], dbg_state[k]}, 32'd0);
      end
      for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;

      // Single requests and latency sweep
      for (int i = 0; i < 6; i++) do_op(vt[i].k, vt[i].p, vt[i].op, vt[i].a, vt[i].b, vt[i].e);

      // Simultaneous requests held from reset on instance 0
      @(negedge clk);
      rst_n[0] = 1'b0;
      set_req(0, 1'b0, 1'b1, 5'h02, 32'h00000005, 32'h00000003);
      set_req(0, 1'b1, 1'b1, 5'h04, 32'h000000F0, 32'h0000000F);
      #1;
      check("ready_in_reset", {30'b0, req0_ready[0], req1_ready[0]}, 32'd0);
      @(negedge clk);
      rst_n[0] = 1'b1;
      ng = 0; nn = 0; both = 0;
      for (int i = 0; i < 200 && ng < 4; i++) begin
         #1;
         if (req0_ready[0] && req1_ready[0]) both = 1;
         if (req0_ready[0] || req1_ready[0]) begin
            gr[ng] = req1_ready[0] ? 1 : 0;
            gt[ng] = nn;
            ng++;
         end
         @(negedge clk);
         nn++;
      end
      set_req(0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
      set_req(0, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
      check("two_readies", {31'b0, both}, 32'd0);
      check("grant_count", ng, 4);
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_SCHED_PRIO_EN
         check("grant_order", gr[i], 0);
`else
         check("grant_order", gr[i], i % 2);
`endif
         if (i > 0) check("throughput", gt[i] - gt[i-1], lat_of(0) + 3);
      end
      repeat (6) @(negedge clk);

      // Response backpressure on instance 0
      rsp1_ready[0] = 1'b0;
      set_req(0, 1'b1, 1'b1, 5'h06, 32'h0000FF00, 32'h00FF00FF);
      #1;
      check("bp_req1_ready", {31'b0, req1_ready[0]}, 32'd1);
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 5'h0, 32'h0, 32'h0);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (rsp1_valid[0]) begin got = 1; break; end
      end
      check("bp_rsp1_valid", {31'b0, got}, 32'd1);
      d = rsp_data[0];
      check("bp_data", d, 32'h00FFFFFF);
      set_req(0, 1'b0, 1'b1, 5'h0A, 32'h01020304, 32'h10203040);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (!rsp1_valid[0] || rsp_data[0] !== d || !busy[0] || req0_ready[0] || rsp0_valid[0])
            bad = 1;
      end
      check("bp_stall_stable", {31'b0, bad}, 32'd0);
      rsp1_ready[0] = 1'b1;
      @(negedge clk);
      #1;
      check("bp_req0_ready_after", {30'b0, req0_ready[0], rsp1_valid[0]}, 32'd2);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
      got = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         #1;
         if (rsp0_valid[0]) begin got = 1; break; end
      end
      check("bp_rsp0_after", {31'b0, got}, 32'd1);
      check("bp_rsp0_data", rsp_data[0], 32'h11223344);
      @(negedge clk);

      // Reset mid-WAIT on instance 2 (ALU_LAT=4)
      set_req(2, 1'b0, 1'b1, 5'h0C, 32'h0000ABCD, 32'h00001111);
      #1;
      check("rst_req_ready", {31'b0, req0_ready[2]}, 32'd1);
      @(negedge clk);
      set_req(2, 1'b0, 1'b0, 5'h0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_wait", {30'b0, dbg_state[2]}, 32'd2);
      rst_n[2] = 1'b0;
      #1;
      check("rst_async_flags", {27'b0, rsp0_valid[2], rsp1_valid[2], alu_enable[2],
                                busy[2], req0_ready[2]}, 32'd0);
      check("rst_async_data", rsp_data[2] | alu_a[2] | alu_b[2], 32'd0);
      check("rst_async_state", {25'b0, alu_opcode[2], dbg_state[2]}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n[2] = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (rsp0_valid[2] || rsp1_valid[2] || busy[2]) bad = 1;
      end
      check("rst_no_response", {31'b0, bad}, 32'd0);
      do_op(vt[6].k, vt[6].p, vt[6].op, vt[6].a, vt[6].b, vt[6].e);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
